// File: rtl/adc_line_reader.sv
// Reads one captured line out of the pixel line RAM and streams it as 16-bit
// pixels with sof/eol markers, hiding the RAM read latency behind a small FIFO.
module adc_line_reader #(
   parameter int unsigned          ADDR_W  = 9,
   parameter logic [ADDR_W-1:0]    PIX_NUM = ADDR_W'(511),
   parameter int unsigned          RD_LAT  = 1,
   parameter int unsigned          FIFO_D  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line_done_in,
   output logic              ram_rd_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   input  logic [31:0]       ram_data_in,
   output logic [15:0]       m_data_o,
   output logic              m_valid_o,
   input  logic              m_ready_in,
   output logic              m_sof_o,
   output logic              m_eol_o,
   output logic              busy_o,
   output logic              overrun_o,
   output logic [15:0]       line_cnt_o
);

   localparam int unsigned PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned ENT_W = 18;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [RD_LAT-1:0]  tag;
   logic [SUM_W-1:0]   inflight;
   logic [CNT_W-1:0]   fifo_cnt;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [ENT_W-1:0]   mem [FIFO_D];
   logic [ENT_W-1:0]   head;
   logic [ADDR_W-1:0]  ret_idx;
   logic               credit_ok;
   logic               start;
   logic               last_rd;
   logic               push;
   logic               pop;
   logic               eol_hs;
   logic [15:0]        unused_hi;

   assign unused_hi = ram_data_in[31:16];

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (line_done_in) state_nxt = READ;
         READ:    if (last_rd)      state_nxt = DRAIN;
         DRAIN:   if (eol_hs)       state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs; reads only when the FIFO can absorb every read in flight
   always_comb begin
      ram_rd_o = 1'b0;
      busy_o   = 1'b0;
      if (state == READ) ram_rd_o = credit_ok;
      if (state != IDLE) busy_o   = 1'b1;
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + SUM_W'(tag[i]);
   end

   assign credit_ok = (SUM_W'(fifo_cnt) + inflight) < SUM_W'(FIFO_D);
   assign start     = (state == IDLE) && line_done_in;
   assign last_rd   = ram_rd_o && (ram_addr_o == PIX_NUM);
   assign push      = tag[RD_LAT-1];
   assign head      = mem[rd_ptr];
   assign m_valid_o = (fifo_cnt != '0);
   assign pop       = m_valid_o && m_ready_in;
   assign eol_hs    = pop && head[16];
   assign m_data_o  = m_valid_o ? head[15:0] : 16'd0;
   assign m_sof_o   = m_valid_o && head[17];
   assign m_eol_o   = m_valid_o && head[16];

   // Entry layout: {sof, eol, pixel}; markers derived from the return index
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {ret_idx == '0, ret_idx == PIX_NUM, ram_data_in[15:0]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ram_addr_o <= '0;
         tag        <= '0;
         ret_idx    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         overrun_o  <= 1'b0;
         line_cnt_o <= '0;
      end else begin
         overrun_o <= line_done_in && (state != IDLE);
         tag       <= RD_LAT'({tag, ram_rd_o});
         if (start)                     ram_addr_o <= '0;
         else if (ram_rd_o && !last_rd) ram_addr_o <= ram_addr_o + ADDR_W'(1);
         if (start)     ret_idx <= '0;
         else if (push) ret_idx <= ret_idx + ADDR_W'(1);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: ;
         endcase
         if (eol_hs) line_cnt_o <= line_cnt_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_adc_line_reader.sv
// Runs two readers side by side (RD_LAT=1 and RD_LAT=2) against RAM models and
// checks the pixel streams against the expected line contents a^16'hA5A5.
module tb_adc_line_reader;

   localparam int NPIX = 512;

   logic        clk;
   logic        rst_n;
   logic        ready;
   logic        clr;
   logic        line_done [2];
   logic        ram_rd    [2];
   logic [8:0]  ram_addr  [2];
   logic [31:0] ram_data  [2];
   logic [15:0] m_data    [2];
   logic        m_valid   [2];
   logic        m_sof     [2];
   logic        m_eol     [2];
   logic        busy      [2];
   logic        overrun   [2];
   logic [15:0] line_cnt  [2];

   int cyc;
   int compares;
   int errors;

   int          beat_n          [2];
   int          rd_n            [2];
   int          pops            [2];
   int          ovr_n           [2];
   int          credit_viol     [2];
   int          first_rd_cyc    [2];
   int          first_valid_cyc [2];
   logic [8:0]  first_rd_addr   [2];
   logic [15:0] beat_data [2][2048];
   bit          beat_sof  [2][2048];
   bit          beat_eol  [2][2048];
   int          beat_cyc  [2][2048];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [31:0] p0;
      logic [31:0] p1;

      adc_line_reader #(.ADDR_W(9), .PIX_NUM(9'd511), .RD_LAT(g + 1), .FIFO_D(4)) u_dut (
         .clk(clk), .rst_n(rst_n), .line_done_in(line_done[g]),
         .ram_rd_o(ram_rd[g]), .ram_addr_o(ram_addr[g]), .ram_data_in(ram_data[g]),
         .m_data_o(m_data[g]), .m_valid_o(m_valid[g]), .m_ready_in(ready),
         .m_sof_o(m_sof[g]), .m_eol_o(m_eol[g]), .busy_o(busy[g]),
         .overrun_o(overrun[g]), .line_cnt_o(line_cnt[g])
      );

      // RAM model: upper half is junk the reader must drop
      always @(posedge clk) begin
         p0 <= ram_rd[g] ? {16'($urandom), 16'(ram_addr[g]) ^ 16'hA5A5} : 32'hFFFF_0BAD;
         p1 <= p0;
      end
      assign ram_data[g] = (g == 0) ? p0 : p1;
   end

   // Stream monitor: records handshakes, read issue and overrun pulses
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (clr) begin
            beat_n[k] = 0; rd_n[k] = 0; pops[k] = 0; ovr_n[k] = 0; credit_viol[k] = 0;
            first_rd_cyc[k] = -1; first_valid_cyc[k] = -1; first_rd_addr[k] = '0;
         end else begin
            if (ram_rd[k]) begin
               if (rd_n[k] - pops[k] >= 4) credit_viol[k]++;
               if (rd_n[k] == 0) begin
                  first_rd_cyc[k]  = cyc;
                  first_rd_addr[k] = ram_addr[k];
               end
               rd_n[k]++;
            end
            if (m_valid[k] && first_valid_cyc[k] < 0) first_valid_cyc[k] = cyc;
            if (m_valid[k] && ready) begin
               if (beat_n[k] < 2048) begin
                  beat_data[k][beat_n[k]] = m_data[k];
                  beat_sof[k][beat_n[k]]  = m_sof[k];
                  beat_eol[k][beat_n[k]]  = m_eol[k];
                  beat_cyc[k][beat_n[k]]  = cyc;
               end
               beat_n[k]++;
               pops[k]++;
            end
            if (overrun[k]) ovr_n[k]++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      clr = 1'b1;
      @(negedge clk);
      #1 clr = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ready = 1'b0; line_done[0] = 1'b0; line_done[1] = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      clear_mon();
   endtask

   task automatic pulse(output int t);
      line_done[0] = 1'b1; line_done[1] = 1'b1; t = cyc;
      tick();
      line_done[0] = 1'b0; line_done[1] = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int bound);
      int n = 0;
      while ((busy[0] || busy[1]) && n < bound) begin tick(); n++; end
      compares++;
      if (busy[0] || busy[1]) begin
         errors++;
         $display("FAIL %s timeout: busy=%b%b after %0d cycles, required 00", name, busy[0], busy[1], n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         compares++;
         if ({ram_rd[k], ram_addr[k], m_data[k], m_valid[k], m_sof[k], m_eol[k], busy[k],
              overrun[k], line_cnt[k]} !== 49'd0) begin
            errors++;
            $display("FAIL reset u%0d: rd=%b addr=%0d data=%h v=%b sof=%b eol=%b busy=%b ovr=%b cnt=%0d, required all 0",
                     k, ram_rd[k], ram_addr[k], m_data[k], m_valid[k], m_sof[k], m_eol[k], busy[k], overrun[k], line_cnt[k]);
         end
      end
      repeat (5) tick();
      for (int k = 0; k < 2; k++) begin
         compares++;
         if (rd_n[k] !== 0 || busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL idle u%0d: reads=%0d busy=%b, required 0 and 0", k, rd_n[k], busy[k]);
         end
      end
   endtask

   task automatic test_single_line();
      int t;
      do_reset();
      ready = 1'b1;
      pulse(t);
      wait_idle("line1", 1000);
      for (int k = 0; k < 2; k++) begin
         int bad = 0; int fb = -1;
         compares++;
         if (first_rd_cyc[k] !== t + 1) begin
            errors++; $display("FAIL line1 u%0d first read at %0d, required %0d", k, first_rd_cyc[k], t + 1);
         end
         compares++;
         if (first_valid_cyc[k] !== t + k + 3) begin
            errors++; $display("FAIL line1 u%0d first valid at %0d, required %0d", k, first_valid_cyc[k], t + k + 3);
         end
         compares++;
         if (beat_n[k] !== NPIX) begin
            errors++; $display("FAIL line1 u%0d beats %0d, required %0d", k, beat_n[k], NPIX);
         end
         for (int i = 0; i < NPIX; i++)
            if (beat_data[k][i] !== (16'(i) ^ 16'hA5A5) || beat_sof[k][i] !== (i == 0) ||
                beat_eol[k][i] !== (i == NPIX - 1) || beat_cyc[k][i] !== t + k + 3 + i) begin
               bad++; if (fb < 0) fb = i;
            end
         compares++;
         if (bad != 0) begin
            errors++;
            $display("FAIL line1 u%0d sequence: %0d bad beats, first at %0d, required 0", k, bad, fb);
         end
         compares++;
         if (line_cnt[k] !== 16'd1 || ovr_n[k] !== 0) begin
            errors++; $display("FAIL line1 u%0d line_cnt=%0d overruns=%0d, required 1 and 0", k, line_cnt[k], ovr_n[k]);
         end
      end
   endtask

   task automatic test_random_ready();
      int t; int n = 0;
      do_reset();
      pulse(t);
      while ((busy[0] || busy[1]) && n < 8000) begin ready = 1'($urandom_range(0, 1)); tick(); n++; end
      ready = 1'b1;
      wait_idle("random", 10);
      for (int k = 0; k < 2; k++) begin
         int bad = 0; int fb = -1;
         compares++;
         if (beat_n[k] !== NPIX) begin
            errors++; $display("FAIL random u%0d beats %0d, required %0d", k, beat_n[k], NPIX);
         end
         for (int i = 0; i < NPIX; i++)
            if (beat_data[k][i] !== (16'(i) ^ 16'hA5A5) || beat_sof[k][i] !== (i == 0) ||
                beat_eol[k][i] !== (i == NPIX - 1)) begin
               bad++; if (fb < 0) fb = i;
            end
         compares++;
         if (bad != 0) begin
            errors++; $display("FAIL random u%0d sequence: %0d bad beats, first at %0d, required 0", k, bad, fb);
         end
         compares++;
         if (credit_viol[k] !== 0) begin
            errors++; $display("FAIL random u%0d reads issued with 4 outstanding: %0d, required 0", k, credit_viol[k]);
         end
         compares++;
         if (line_cnt[k] !== 16'd1) begin
            errors++; $display("FAIL random u%0d line_cnt=%0d, required 1", k, line_cnt[k]);
         end
      end
   endtask

   task automatic test_overrun();
      int t;
      do_reset();
      ready = 1'b1;
      pulse(t);
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < 2; k++)
            line_done[k] = (cyc == t + k + 103) || (cyc == t + k + 514);
         tick();
      end
      line_done[0] = 1'b0; line_done[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         int bad = 0;
         compares++;
         if (ovr_n[k] !== 2) begin
            errors++; $display("FAIL overrun u%0d pulses %0d, required 2", k, ovr_n[k]);
         end
         for (int i = 0; i < NPIX; i++)
            if (beat_data[k][i] !== (16'(i) ^ 16'hA5A5) || beat_sof[k][i] !== (i == 0) ||
                beat_eol[k][i] !== (i == NPIX - 1) || beat_cyc[k][i] !== t + k + 3 + i) bad++;
         compares++;
         if (bad != 0 || beat_n[k] !== NPIX) begin
            errors++; $display("FAIL overrun u%0d transfer: beats=%0d bad=%0d, required %0d and 0", k, beat_n[k], bad, NPIX);
         end
         compares++;
         if (line_cnt[k] !== 16'd1 || busy[k] !== 1'b0 || rd_n[k] !== NPIX) begin
            errors++;
            $display("FAIL overrun u%0d after: line_cnt=%0d busy=%b reads=%0d, required 1, 0, %0d", k, line_cnt[k], busy[k], rd_n[k], NPIX);
         end
      end
   endtask

   task automatic test_mid_reset();
      int t; int n = 0;
      do_reset();
      ready = 1'b1;
      pulse(t);
      while (beat_n[0] < 200 && n < 500) begin tick(); n++; end
      compares++;
      if (beat_n[0] < 200) begin
         errors++; $display("FAIL midreset timeout: beats=%0d, required 200", beat_n[0]);
      end
      rst_n = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
         compares++;
         if ({ram_rd[k], ram_addr[k], m_data[k], m_valid[k], m_sof[k], m_eol[k], busy[k],
              overrun[k], line_cnt[k]} !== 49'd0) begin
            errors++;
            $display("FAIL midreset u%0d outputs: rd=%b addr=%0d data=%h v=%b sof=%b eol=%b busy=%b cnt=%0d, required all 0",
                     k, ram_rd[k], ram_addr[k], m_data[k], m_valid[k], m_sof[k], m_eol[k], busy[k], line_cnt[k]);
         end
      end
      rst_n = 1'b1;
      clear_mon();
      pulse(t);
      wait_idle("restart", 1000);
      for (int k = 0; k < 2; k++) begin
         int bad = 0;
         for (int i = 0; i < NPIX; i++)
            if (beat_data[k][i] !== (16'(i) ^ 16'hA5A5) || beat_sof[k][i] !== (i == 0) ||
                beat_eol[k][i] !== (i == NPIX - 1)) bad++;
         compares++;
         if (bad != 0 || beat_n[k] !== NPIX || first_rd_addr[k] !== 9'd0) begin
            errors++;
            $display("FAIL restart u%0d: beats=%0d bad=%0d first addr=%0d, required %0d, 0, 0", k, beat_n[k], bad, first_rd_addr[k], NPIX);
         end
         compares++;
         if (line_cnt[k] !== 16'd1) begin
            errors++; $display("FAIL restart u%0d line_cnt=%0d, required 1", k, line_cnt[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int t;
      bit sent [2]; bit pend [2]; bit was_busy [2];
      do_reset();
      ready = 1'b1;
      pulse(t);
      for (int k = 0; k < 2; k++) begin sent[k] = 0; pend[k] = 0; was_busy[k] = 1; end
      for (int n = 0; n < 1300; n++) begin
         for (int k = 0; k < 2; k++) begin
            line_done[k] = pend[k];
            if (pend[k]) begin sent[k] = 1; pend[k] = 0; end
            else if (!sent[k] && was_busy[k] && !busy[k]) pend[k] = 1;
            was_busy[k] = busy[k];
         end
         tick();
      end
      line_done[0] = 1'b0; line_done[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         int bad = 0;
         for (int i = 0; i < 2 * NPIX; i++)
            if (beat_data[k][i] !== (16'(i % NPIX) ^ 16'hA5A5) || beat_sof[k][i] !== (i % NPIX == 0) ||
                beat_eol[k][i] !== (i % NPIX == NPIX - 1)) bad++;
         compares++;
         if (!sent[k] || bad != 0 || beat_n[k] !== 2 * NPIX) begin
            errors++; $display("FAIL b2b u%0d: sent=%b beats=%0d bad=%0d, required 1, %0d, 0", k, sent[k], beat_n[k], bad, 2 * NPIX);
         end
         compares++;
         if (line_cnt[k] !== 16'd2 || ovr_n[k] !== 0 || busy[k] !== 1'b0) begin
            errors++; $display("FAIL b2b u%0d: line_cnt=%0d overruns=%0d busy=%b, required 2, 0, 0", k, line_cnt[k], ovr_n[k], busy[k]);
         end
      end
   endtask

   task automatic test_stall();
      int t; int n = 0;
      logic [15:0] held [2]; logic held_sof [2]; int unstable [2];
      do_reset();
      pulse(t);
      while (!(m_valid[0] && m_valid[1]) && n < 20) begin tick(); n++; end
      compares++;
      if (!(m_valid[0] && m_valid[1])) begin
         errors++; $display("FAIL stall timeout: valid=%b%b, required 11", m_valid[0], m_valid[1]);
      end
      for (int k = 0; k < 2; k++) begin held[k] = m_data[k]; held_sof[k] = m_sof[k]; unstable[k] = 0; end
      repeat (50) begin
         tick();
         for (int k = 0; k < 2; k++)
            if (m_valid[k] !== 1'b1 || m_data[k] !== held[k] || m_sof[k] !== held_sof[k]) unstable[k]++;
      end
      for (int k = 0; k < 2; k++) begin
         compares++;
         if (held[k] !== 16'hA5A5 || held_sof[k] !== 1'b1 || unstable[k] !== 0) begin
            errors++;
            $display("FAIL stall u%0d hold: data=%h sof=%b unstable cycles=%0d, required a5a5, 1, 0", k, held[k], held_sof[k], unstable[k]);
         end
         compares++;
         if (rd_n[k] !== 4) begin
            errors++; $display("FAIL stall u%0d reads while stalled %0d, required 4", k, rd_n[k]);
         end
      end
      ready = 1'b1;
      wait_idle("stall", 1000);
      for (int k = 0; k < 2; k++) begin
         int bad = 0;
         for (int i = 0; i < NPIX; i++)
            if (beat_data[k][i] !== (16'(i) ^ 16'hA5A5) || beat_sof[k][i] !== (i == 0) ||
                beat_eol[k][i] !== (i == NPIX - 1)) bad++;
         compares++;
         if (bad != 0 || beat_n[k] !== NPIX || line_cnt[k] !== 16'd1 || credit_viol[k] !== 0) begin
            errors++;
            $display("FAIL stall u%0d resume: beats=%0d bad=%0d line_cnt=%0d credit=%0d, required %0d, 0, 1, 0",
                     k, beat_n[k], bad, line_cnt[k], credit_viol[k], NPIX);
         end
      end
   endtask

   initial begin
      compares = 0; errors = 0; cyc = 0;
      clr = 1'b1; rst_n = 1'b0; ready = 1'b0;
      line_done[0] = 1'b0; line_done[1] = 1'b0;
      test_reset();
      test_single_line();
      test_random_ready();
      test_overrun();
      test_mid_reset();
      test_back_to_back();
      test_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
      $finish;
   end

endmodule
